ddr2_read_return: RTL and testbench

Read-data return engine for the DDR2 controller datapath. It sits directly downstream of the 8-word read-capture ring buffer. It schedules that buffer's single-cycle `listen` pulse a fixed CAS-derived delay after each accepted read, walks `readPtr` across the captured burst, and copies every word into a 16-entry return FIFO. Words leave the FIFO on a tagged valid/ready interface. Credit-based admission guarantees that no captured word is ever dropped or overwritten.

---
 rtl/ddr2_read_return_if.sv | 29 ++
 rtl/ddr2_read_return.sv | 90 +++++++++
 tb/tb_ddr2_read_return.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_read_return_if.sv
// ddr2_read_return_if: read-issue, ring-buffer and tagged return signals of the DDR2 read return engine
// master: read issuer, ring-buffer data source and return consumer
// slave : ddr2_read_return
//   rd_issue/rd_tag/rd_accept   read admission handshake
//   listen/readPtr/rb_dout      ring-buffer arm pulse, word select and selected word
//   ret_valid/ret_ready/ret_*   tagged return stream, ret_last marks word 7 of a burst
//   busy                        any accepted read not yet fully popped
interface ddr2_read_return_if #(parameter int TAG_W = 4);
    logic             rd_issue;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_accept;
    logic             listen;
    logic [2:0]       readPtr;
    logic [15:0]      rb_dout;
    logic             ret_valid;
    logic             ret_ready;
    logic [15:0]      ret_data;
    logic [TAG_W-1:0] ret_tag;
    logic             ret_last;
    logic             busy;
    modport master (
        output rd_issue, rd_tag, rb_dout, ret_ready,
        input  rd_accept, listen, readPtr, ret_valid, ret_data, ret_tag, ret_last, busy
    );
    modport slave (
        input  rd_issue, rd_tag, rb_dout, ret_ready,
        output rd_accept, listen, readPtr, ret_valid, ret_data, ret_tag, ret_last, busy
    );
endinterface

// File: rtl/ddr2_read_return.sv
// ddr2_read_return: schedules ring-buffer listen pulses, copies captured bursts into a tagged 16-entry return FIFO
// clk      controller clock, rising edge
// reset_n  asynchronous active-low reset
// bus      ddr2_read_return_if.slave: read admission, ring-buffer access, tagged return stream, busy
module ddr2_read_return #(
    parameter int CL_CYCLES = 4,
    parameter int TAG_W     = 4
) (
    input logic               clk,
    input logic               reset_n,
    ddr2_read_return_if.slave bus
);
    localparam int W = 17 + TAG_W;

    logic [3:0]           sp_q, sp_d;
    logic [CL_CYCLES-1:0] sched_q, sched_d;
    logic                 arm_q;
    logic                 cp_q, cp_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [4:0]           res_q, res_d;
    logic [4:0]           wp_q, rp_q;
    logic [1:0]           tq_wp_q, tq_rp_q;
    logic [2:0]           tq_cnt_q;
    logic [TAG_W-1:0]     tq_q [4];
    logic [W-1:0]         mem_q [16];
    logic [W-1:0]         head;
    logic [4:0]           occ, used;
    logic                 accept, push, pop, last_w, tq_pop;

    // Admission only depends on registered state; used <= 8 means at least 8 free credits.
    assign bus.rd_accept = (sp_q == 4'd0) && (used <= 5'd8) && (tq_cnt_q != 3'd4);
    assign bus.listen    = sched_q[CL_CYCLES-1];
    assign bus.readPtr   = ptr_q;
    assign bus.ret_valid = wp_q != rp_q;
    assign bus.ret_data  = bus.ret_valid ? head[W-1 -: 16] : 16'd0;
    assign bus.ret_tag   = bus.ret_valid ? head[TAG_W:1] : '0;
    assign bus.ret_last  = bus.ret_valid && head[0];
    assign bus.busy      = (tq_cnt_q != 3'd0) || bus.ret_valid || (|sched_q);

    always_comb begin
        occ     = wp_q - rp_q;
        used    = occ + res_q;
        head    = mem_q[rp_q[3:0]];
        accept  = bus.rd_issue && bus.rd_accept;
        pop     = bus.ret_valid && bus.ret_ready;
        push    = cp_q;
        last_w  = ptr_q == 3'd7;
        tq_pop  = push && last_w;
        sp_d    = accept ? 4'd7 : (sp_q != 4'd0 ? sp_q - 4'd1 : 4'd0);
        sched_d = {sched_q[CL_CYCLES-2:0], accept};
        // A new arm on the r7 cycle restarts the walk at 0, giving contiguous copy phases.
        cp_d    = arm_q || (cp_q && !last_w);
        ptr_d   = cp_q ? ptr_q + 3'd1 : 3'd0;
        res_d   = res_q + (accept ? 5'd8 : 5'd0) - (push ? 5'd1 : 5'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q     <= '0;
            sched_q  <= '0;
            arm_q    <= 1'b0;
            cp_q     <= 1'b0;
            ptr_q    <= '0;
            res_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            tq_wp_q  <= '0;
            tq_rp_q  <= '0;
            tq_cnt_q <= '0;
        end else begin
            sp_q     <= sp_d;
            sched_q  <= sched_d;
            arm_q    <= bus.listen;
            cp_q     <= cp_d;
            ptr_q    <= ptr_d;
            res_q    <= res_d;
            wp_q     <= wp_q + {4'd0, push};
            rp_q     <= rp_q + {4'd0, pop};
            tq_wp_q  <= tq_wp_q + {1'b0, accept};
            tq_rp_q  <= tq_rp_q + {1'b0, tq_pop};
            tq_cnt_q <= tq_cnt_q + {2'd0, accept} - {2'd0, tq_pop};
        end
    end

    // Storage arrays need no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (accept) tq_q[tq_wp_q] <= bus.rd_tag;
        if (push) mem_q[wp_q[3:0]] <= {bus.rb_dout, tq_q[tq_rp_q], last_w};
    end
endmodule

// File: tb/tb_ddr2_read_return.sv
module tb_ddr2_read_return;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_read_return_if #(.TAG_W(4)) bus ();
    ddr2_read_return_if #(.TAG_W(4)) bus2 ();
    ddr2_read_return_if #(.TAG_W(4)) bus16 ();

    ddr2_read_return #(.CL_CYCLES(4),  .TAG_W(4)) dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
    ddr2_read_return #(.CL_CYCLES(2),  .TAG_W(4)) dut2  (.clk(clk), .reset_n(reset_n), .bus(bus2));
    ddr2_read_return #(.CL_CYCLES(16), .TAG_W(4)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
        logic        l;
    } ent_t;

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;
    int n_last = 0;
    ent_t exp_q[$];
    logic [15:0] base_q[$];
    logic [15:0] cur_base;
    logic ld;
    bit done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ring-buffer model: burst base is latched one cycle after listen, so it covers readPtr 0..7.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld <= 1'b0;
            cur_base <= 16'd0;
        end else begin
            ld <= bus.listen;
            if (ld) cur_base <= (base_q.size() != 0) ? base_q.pop_front() : 16'hdead;
        end
    end
    assign bus.rb_dout = cur_base + {13'd0, bus.readPtr};

    assign bus2.rb_dout = 16'd0;
    assign bus2.ret_ready = 1'b1;
    assign bus2.rd_tag = 4'd0;
    assign bus16.rb_dout = 16'd0;
    assign bus16.ret_ready = 1'b1;
    assign bus16.rd_tag = 4'd0;

    // Scoreboard monitor
    always @(negedge clk) begin
        ent_t e;
        if (reset_n && bus.ret_valid && bus.ret_ready) begin
            n_pop++;
            if (bus.ret_last) n_last++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got data %0h tag %0h with nothing expected", bus.ret_data, bus.ret_tag);
            end else begin
                e = exp_q.pop_front();
                chk("ret_data", {16'd0, bus.ret_data}, {16'd0, e.d});
                chk("ret_tag", {28'd0, bus.ret_tag}, {28'd0, e.t});
                chk("ret_last", {31'd0, bus.ret_last}, {31'd0, e.l});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [3:0] tag, input logic [15:0] base);
        for (int k = 0; k < 8; k++) exp_q.push_back(ent_t'{d: base + 16'(k), t: tag, l: (k == 7)});
        base_q.push_back(base);
    endtask

    task automatic issue(input logic [3:0] tag, input logic [15:0] base);
        bit ok;
        ok = 0;
        bus.rd_issue = 1'b1;
        bus.rd_tag = tag;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.rd_accept) begin
                expect_burst(tag, base);
                ok = 1;
            end
            tick();
        end
        bus.rd_issue = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: tag %0h never accepted", tag);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (!bus.busy && exp_q.size() == 0) ok = 1;
            else tick();
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: busy %0b pending %0d expected idle", bus.busy, exp_q.size());
        end
    endtask

    task automatic chk_reset();
        chk("rst_rd_accept", {31'd0, bus.rd_accept}, 1);
        chk("rst_listen", {31'd0, bus.listen}, 0);
        chk("rst_readPtr", {29'd0, bus.readPtr}, 0);
        chk("rst_ret_valid", {31'd0, bus.ret_valid}, 0);
        chk("rst_ret_data", {16'd0, bus.ret_data}, 0);
        chk("rst_ret_tag", {28'd0, bus.ret_tag}, 0);
        chk("rst_ret_last", {31'd0, bus.ret_last}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, l0;
        bus.rd_issue = 1'b0;
        bus.rd_tag = 4'd0;
        bus.ret_ready = 1'b0;
        bus2.rd_issue = 1'b0;
        bus16.rd_issue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        reset_n = 1'b1;
        tick();

        // Single read, CL=4, tag 5
        bus.ret_ready = 1'b1;
        chk("t1_accept_c0", {31'd0, bus.rd_accept}, 1);
        chk("t1_listen_c0", {31'd0, bus.listen}, 0);
        issue(4'd5, 16'h1000);
        for (int c = 1; c <= 16; c++) begin
            chk("t1_listen", {31'd0, bus.listen}, (c == 4) ? 1 : 0);
            chk("t1_readPtr", {29'd0, bus.readPtr}, (c >= 6 && c <= 13) ? c - 6 : 0);
            chk("t1_ret_valid", {31'd0, bus.ret_valid}, (c >= 7 && c <= 14) ? 1 : 0);
            chk("t1_ret_last", {31'd0, bus.ret_last}, (c == 14) ? 1 : 0);
            tick();
        end
        wait_idle();

        // rd_issue held high: accepts every 8 cycles only
        for (int c = 0; c < 24; c++) begin
            bus.rd_issue = 1'b1;
            bus.rd_tag = 4'(1 + c / 8);
            chk("t2_accept", {31'd0, bus.rd_accept}, (c % 8 == 0) ? 1 : 0);
            chk("t2_listen", {31'd0, bus.listen}, (c % 8 == 4) ? 1 : 0);
            if (bus.rd_accept) expect_burst(4'(1 + c / 8), 16'h2000 + 16'(16 * c));
            tick();
        end
        bus.rd_issue = 1'b0;
        wait_idle();

        // Credit backpressure with stalled consumer
        bus.ret_ready = 1'b0;
        issue(4'd6, 16'h3000);
        issue(4'd7, 16'h3010);
        for (int i = 0; i < 14; i++) begin
            chk("t3_accept_full", {31'd0, bus.rd_accept}, 0);
            tick();
        end
        chk("t3_valid_full", {31'd0, bus.ret_valid}, 1);
        bus.ret_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_accept_draining", {31'd0, bus.rd_accept}, 0);
            tick();
        end
        bus.ret_ready = 1'b0;
        chk("t3_accept_reopen", {31'd0, bus.rd_accept}, 1);
        bus.ret_ready = 1'b1;
        wait_idle();

        // 50 reads with random consumer stalls
        l0 = n_last;
        p0 = n_pop;
        done = 0;
        fork
            begin
                for (int i = 0; i < 50; i++) issue(4'(i % 16), 16'h4000 + 16'(16 * i));
                done = 1;
            end
            begin
                while (!done) begin
                    bus.ret_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.ret_ready = 1'b1;
        wait_idle();
        chk("t4_words", n_pop - p0, 400);
        chk("t4_lasts", n_last - l0, 50);

        // Asynchronous reset in cycle 9 of a burst
        issue(4'd9, 16'h5000);
        repeat (8) tick();
        reset_n = 1'b0;
        #1;
        chk_reset();
        exp_q.delete();
        base_q.delete();
        tick();
        chk_reset();
        tick();
        reset_n = 1'b1;
        tick();
        p0 = n_pop;
        issue(4'hA, 16'h6000);
        wait_idle();
        chk("t5_fresh_words", n_pop - p0, 8);

        // CL_CYCLES=2 and CL_CYCLES=16 builds
        chk("t6_accept2", {31'd0, bus2.rd_accept}, 1);
        chk("t6_accept16", {31'd0, bus16.rd_accept}, 1);
        bus2.rd_issue = 1'b1;
        bus16.rd_issue = 1'b1;
        tick();
        bus2.rd_issue = 1'b0;
        bus16.rd_issue = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            chk("t6_listen2", {31'd0, bus2.listen}, (c == 2) ? 1 : 0);
            chk("t6_valid2", {31'd0, bus2.ret_valid}, (c >= 5 && c <= 12) ? 1 : 0);
            chk("t6_listen16", {31'd0, bus16.listen}, (c == 16) ? 1 : 0);
            chk("t6_valid16", {31'd0, bus16.ret_valid}, (c >= 19 && c <= 26) ? 1 : 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
